// File: rtl/ir_move_pkg.sv
// Shared types for the IR move scheduler: direction codes, FSM states, widths.
package ir_move_pkg;

  localparam int unsigned DIR_W = 2;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} sched_state_t;

endpackage

// File: rtl/ir_move_fifo.sv
// Synchronous FIFO for move commands. A push while full is accepted only when
// a pop happens in the same cycle; otherwise it is silently refused (the
// caller flags the overflow).
// Ports: clk, rst_n (sync, active-low), push/wr_data, pop/rd_data (head,
// combinational), full, empty, count (registered occupancy).
module ir_move_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_move_scheduler.sv
// Validates decoded IR direction strobes, buffers them as 2-bit move codes and
// releases at most one move per FRAMES_PER_MOVE frame ticks over valid/ready.
// Ports: Clock, Reset_n (sync, active-low); In_Valid + In_Up/Down/Left/Right
// decoder inputs; Frame_Tick pacing pulse; Move_Valid/Move_Dir/Move_Ready
// handshake; Fifo_Count occupancy; Drop_Pulse (invalid or overflow);
// Overflow (sticky).
// Optional macro IR_REPEAT_EN adds In_Repeat, which re-pushes the last code.
module ir_move_scheduler
  import ir_move_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FRAMES_PER_MOVE = 2
) (
  input  logic                            Clock,
  input  logic                            Reset_n,
  input  logic                            In_Valid,
  input  logic                            In_Up,
  input  logic                            In_Down,
  input  logic                            In_Left,
  input  logic                            In_Right,
`ifdef IR_REPEAT_EN
  input  logic                            In_Repeat,
`endif
  input  logic                            Frame_Tick,
  input  logic                            Move_Ready,
  output logic                            Move_Valid,
  output logic [DIR_W-1:0]                Move_Dir,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Fifo_Count,
  output logic                            Drop_Pulse,
  output logic                            Overflow
);

  // Keep the counter at least one bit wide when pacing is disabled.
  localparam int unsigned CNT_W = (FRAMES_PER_MOVE > 0) ? $clog2(FRAMES_PER_MOVE + 1) : 1;

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_valid_d;
  logic [DIR_W-1:0] move_dir_d;
  logic             pop_c;
  logic             push_req_c;
  dir_t             push_code_c;
  logic             drop_c;
  logic             ovf_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DIR_W-1:0] fifo_head;

`ifdef IR_REPEAT_EN
  dir_t last_dir_q;
  logic last_valid_q;
`endif

  // Decode: exactly one direction bit makes a move; anything else is dropped.
  always_comb begin
    push_req_c  = 1'b0;
    push_code_c = DIR_UP;
    drop_c      = 1'b0;
    if (In_Valid) begin
      case ({In_Up, In_Down, In_Left, In_Right})
        4'b1000: begin push_req_c = 1'b1; push_code_c = DIR_UP;    end
        4'b0100: begin push_req_c = 1'b1; push_code_c = DIR_DOWN;  end
        4'b0010: begin push_req_c = 1'b1; push_code_c = DIR_LEFT;  end
        4'b0001: begin push_req_c = 1'b1; push_code_c = DIR_RIGHT; end
        default: drop_c = 1'b1;
      endcase
    end
`ifdef IR_REPEAT_EN
    else if (In_Repeat) begin
      if (last_valid_q) begin
        push_req_c  = 1'b1;
        push_code_c = last_dir_q;
      end else begin
        drop_c = 1'b1;
      end
    end
`endif
  end

  // A push into a full FIFO survives only if the FSM pops the same cycle.
  assign ovf_c = push_req_c && fifo_full && !pop_c;

  ir_move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DIR_W)
  ) u_fifo (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .push    (push_req_c),
    .wr_data (push_code_c),
    .pop     (pop_c),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (Fifo_Count)
  );

  // Scheduler FSM: next state, pop request and registered output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    move_valid_d = 1'b0;
    move_dir_d   = Move_Dir;
    pop_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop_c        = 1'b1;
          move_dir_d   = fifo_head;
          move_valid_d = 1'b1;
          state_d      = S_PRESENT;
        end
      end
      S_PRESENT: begin
        move_valid_d = 1'b1;
        if (Move_Ready) begin
          move_valid_d = 1'b0;
          if (FRAMES_PER_MOVE == 32'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = CNT_W'(FRAMES_PER_MOVE);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (Frame_Tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      Move_Valid <= 1'b0;
      Move_Dir   <= '0;
      Drop_Pulse <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      Move_Valid <= move_valid_d;
      Move_Dir   <= move_dir_d;
      Drop_Pulse <= drop_c || ovf_c;
      if (ovf_c) Overflow <= 1'b1;
    end
  end

`ifdef IR_REPEAT_EN
  // Remember the last code actually accepted into the FIFO.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      last_dir_q   <= DIR_UP;
      last_valid_q <= 1'b0;
    end else if (push_req_c && !ovf_c) begin
      last_dir_q   <= push_code_c;
      last_valid_q <= 1'b1;
    end
  end
`endif

endmodule
